// File: rtl/axi_sram_responder_if.sv
// AXI3 bus bundle between the cache/uncache master and the on-chip SRAM responder.
interface axi_sram_responder_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI3 slave over a byte-writable word SRAM; independent read and write FSMs,
// one outstanding transaction per channel, 4-byte beats only.
module axi_sram_responder #(
    parameter int MEM_AW    = 12,
    parameter int INIT_ZERO = 1
) (
    input logic                  clk,
    input logic                  reset,
    axi_sram_responder_if.slave  axi
);
    localparam int unsigned DEPTH     = 1 << MEM_AW;
    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Power-up contents only; reset never touches the array.
    logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};

    function automatic logic wrap_ok(input logic [3:0] len);
        return (len != 4'd0) && ((len & (len + 4'd1)) == 4'd0);
    endfunction

    function automatic logic burst_err(input logic [3:0] len, input logic [1:0] burst);
        return (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok(len));
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        mask = {26'd0, len, 2'b11};
        if (burst == 2'b00)
            return addr;
        else if ((burst == 2'b10) && wrap_ok(len))
            return (addr & ~mask) | ((addr + 32'd4) & mask);
        else
            return addr + 32'd4;
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        return addr[MEM_AW+1:2];
    endfunction

    // Write channel
    w_state_e    w_state_q;
    logic        awready_q, wready_q, bvalid_q, werr_q;
    logic [3:0]  bid_q, wid_q, wlen_q, wcnt_q;
    logic [1:0]  bresp_q, wburst_q;
    logic [31:0] waddr_q, waddr_d;
    logic        we;

    assign we      = (w_state_q == W_DATA) && axi.wvalid && wready_q;
    assign waddr_d = next_addr(waddr_q, wlen_q, wburst_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (axi.awvalid && awready_q) begin
                        wid_q     <= axi.awid;
                        waddr_q   <= axi.awaddr;
                        wlen_q    <= axi.awlen;
                        wburst_q  <= axi.awburst;
                        wcnt_q    <= '0;
                        werr_q    <= burst_err(axi.awlen, axi.awburst);
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (we) begin
                        waddr_q <= waddr_d;
                        // Burst length comes from awlen; wlast only feeds the error flag.
                        if (wcnt_q == wlen_q) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bid_q     <= wid_q;
                            bresp_q   <= (werr_q || !axi.wlast) ? 2'b10 : 2'b00;
                            w_state_q <= W_RESP;
                        end else begin
                            wcnt_q <= wcnt_q + 4'd1;
                            werr_q <= werr_q | axi.wlast;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (axi.wstrb[b])
                    mem_q[word_idx(waddr_q)][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
        end
    end

    // Read channel
    r_state_e    r_state_q;
    logic        arready_q, rvalid_q, rlast_q;
    logic [3:0]  rid_q, rlen_q, rcnt_q;
    logic [1:0]  rresp_q, rburst_q;
    logic [31:0] rdata_q, raddr_q, raddr_d;

    assign raddr_d = next_addr(raddr_q, rlen_q, rburst_q);

    // rdata is sampled from the array at the edge it is presented, so a
    // same-cycle write to that word is seen only by later beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (axi.arvalid && arready_q) begin
                        rid_q     <= axi.arid;
                        raddr_q   <= axi.araddr;
                        rlen_q    <= axi.arlen;
                        rburst_q  <= axi.arburst;
                        rcnt_q    <= '0;
                        rresp_q   <= burst_err(axi.arlen, axi.arburst) ? 2'b10 : 2'b00;
                        rdata_q   <= mem_q[word_idx(axi.araddr)];
                        rlast_q   <= (axi.arlen == 4'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_d;
                            rcnt_q  <= rcnt_q + 4'd1;
                            rdata_q <= mem_q[word_idx(raddr_d)];
                            rlast_q <= ((rcnt_q + 4'd1) == rlen_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;

    logic unused_ok;
    assign unused_ok = ^{axi.awsize, axi.arsize, axi.wid};
endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder: expected R beats and B responses are
// queued as stimulus is issued and retired by a negedge monitor.
module tb_axi_sram_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_sram_responder_if bus ();

    axi_sram_responder #(
        .MEM_AW    (12),
        .INIT_ZERO (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .axi   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [38:0] rq [$];   // {rid, rdata, rresp, rlast}
    logic [5:0]  bq [$];   // {bid, bresp}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] d,
                          input logic [1:0] resp, input logic last);
        rq.push_back({id, d, resp, last});
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = 3'd2; bus.awburst = burst; bus.awvalid = 1'b1;
        for (int k = 0; k < 50 && !bus.awready; k++) tick();
        check("aw_handshake", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        bus.arid = id; bus.araddr = addr; bus.arlen = len;
        bus.arsize = 3'd2; bus.arburst = burst; bus.arvalid = 1'b1;
        for (int k = 0; k < 50 && !bus.arready; k++) tick();
        check("ar_handshake", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0;
        check("r_first_latency", bus.rvalid, 1);
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [1:0] burst,
                               input logic [31:0] d0, input logic [3:0] strb,
                               input int last_beat, input logic [1:0] exp_resp);
        bq.push_back({id, exp_resp});
        send_aw(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata  = d0 + 32'(i);
            bus.wstrb  = strb;
            bus.wlast  = (i == last_beat);
            bus.wvalid = 1'b1;
            for (int k = 0; k < 50 && !bus.wready; k++) tick();
            check("w_handshake", bus.wready, 1);
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (rq.size() != 0 || bq.size() != 0); k++) tick();
        check("drain_pending", 64'(rq.size() + bq.size()), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.rvalid) begin
                    if (rq.size() == 0)
                        check("r_unexpected", bus.rvalid, 0);
                    else if (bus.rready)
                        check("r_beat", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, rq.pop_front());
                    else
                        check("r_stall", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, rq[0]);
                end
                if (bus.bvalid && bus.bready) begin
                    if (bq.size() == 0)
                        check("b_unexpected", bus.bvalid, 0);
                    else
                        check("b_resp", {bus.bid, bus.bresp}, bq.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2;
        bus.awburst = 2'b01; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2;
        bus.arburst = 2'b01; bus.arvalid = 1'b0;
        bus.rready = 1'b1;

        repeat (3) tick();
        check("reset_outs", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                             bus.rlast, bus.bid, bus.rid, bus.bresp, bus.rresp, bus.rdata}, 0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", {bus.arready, bus.awready}, 2'b11);

        // 16-beat line writeback then fill
        write_burst(4'd3, 32'h100, 4'd15, 2'b01, 32'hA0, 4'hF, 15, 2'b00);
        drain();
        for (int i = 0; i < 16; i++) push_r(4'd5, 32'hA0 + 32'(i), 2'b00, i == 15);
        send_ar(4'd5, 32'h100, 4'd15, 2'b01);
        drain();

        // single-beat uncached, partial strobes over zero-initialised word
        write_burst(4'd1, 32'h40, 4'd0, 2'b01, 32'h12345678, 4'b0101, 0, 2'b00);
        drain();
        push_r(4'd2, 32'h00340078, 2'b00, 1'b1);
        send_ar(4'd2, 32'h40, 4'd0, 2'b01);
        drain();

        // R backpressure 1,0,0,1
        write_burst(4'd4, 32'h200, 4'd3, 2'b01, 32'hB0, 4'hF, 3, 2'b00);
        drain();
        for (int i = 0; i < 4; i++) push_r(4'd6, 32'hB0 + 32'(i), 2'b00, i == 3);
        send_ar(4'd6, 32'h200, 4'd3, 2'b01);
        pat = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            bus.rready = pat[c];
            tick();
        end
        bus.rready = 1'b1;
        drain();

        // B backpressure for 5 cycles
        bus.bready = 1'b0;
        write_burst(4'd7, 32'h300, 4'd0, 2'b01, 32'hDEAD0001, 4'hF, 0, 2'b00);
        for (int c = 0; c < 5; c++) begin
            check("b_hold", {bus.bvalid, bus.awready}, 2'b10);
            tick();
        end
        bus.bready = 1'b1;
        drain();

        // WRAP legal and illegal length
        write_burst(4'd8, 32'h20, 4'd3, 2'b01, 32'h1, 4'hF, 3, 2'b00);
        drain();
        push_r(4'd9, 32'd3, 2'b00, 1'b0);
        push_r(4'd9, 32'd4, 2'b00, 1'b0);
        push_r(4'd9, 32'd1, 2'b00, 1'b0);
        push_r(4'd9, 32'd2, 2'b00, 1'b1);
        send_ar(4'd9, 32'h28, 4'd3, 2'b10);
        drain();
        push_r(4'd9, 32'd3, 2'b10, 1'b0);
        push_r(4'd9, 32'd4, 2'b10, 1'b0);
        push_r(4'd9, 32'd0, 2'b10, 1'b1);
        send_ar(4'd9, 32'h28, 4'd2, 2'b10);
        drain();

        // early wlast: all beats still land, SLVERR on B
        write_burst(4'd10, 32'h400, 4'd3, 2'b01, 32'hC0, 4'hF, 1, 2'b10);
        drain();
        for (int i = 0; i < 4; i++) push_r(4'd11, 32'hC0 + 32'(i), 2'b00, i == 3);
        send_ar(4'd11, 32'h400, 4'd3, 2'b01);
        drain();

        // reset while beat 5 of a 16-beat read is presented
        for (int i = 0; i < 16; i++) push_r(4'd12, 32'hA0 + 32'(i), 2'b00, i == 15);
        send_ar(4'd12, 32'h100, 4'd15, 2'b01);
        for (int k = 0; k < 50 && rq.size() > 12; k++) tick();
        check("beats_before_reset", 64'(rq.size()), 12);
        reset = 1'b1;
        tick();
        check("reset_mid_read", {bus.rvalid, bus.rlast, bus.arready, bus.bvalid}, 0);
        reset = 1'b0;
        rq.delete();
        tick();
        check("arready_post_reset", bus.arready, 1);
        push_r(4'd13, 32'hA4, 2'b00, 1'b1);
        send_ar(4'd13, 32'h110, 4'd0, 2'b01);
        drain();
        push_r(4'd14, 32'h00340078, 2'b00, 1'b1);
        send_ar(4'd14, 32'h40, 4'd0, 2'b01);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
